program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Feeds a program into the pipelined CPU's instruction-load port, acting as the transmitter for its LoadInstructions/Instruction receiver.
- Accepts 32-bit words from a host over a valid/ready handshake and buffers the whole program.
- Streams the buffered words back-to-back, one per clock, while driving the CPU's reset so that its load-address counter and PC start from 0.
- Sits between the bench/host and the CPU's Reset, LoadInstructions and Instruction inputs.

Parameters:
DEPTH, 32, program buffer capacity in words (power of 2)
AW, 5, log2(DEPTH)
RST_CYCLES, 2, CPU reset pulse length in cycles after streaming (>=1)

Ports:
clk  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
host_valid  input  1  host word valid
host_data  input  32  host program word
host_last  input  1  marks final word of program (qualified by host_valid)
host_ready  output  1  loader accepts a word this cycle
restart  input  1  in RUN, discard program and return to FILL
CpuReset  output  1  drives CPU Reset (active-high)
LoadInstructions  output  1  drives CPU LoadInstructions
Instruction  output  32  drives CPU Instruction
busy  output  1  high in STREAM and RST2
done  output  1  high in RUN
word_count  output  AW+1  number of words buffered

Behaviour:
- All outputs are registered. Reset asserted (low) at any time forces the following immediately, mid-operation included: state FILL, host_ready=1, CpuReset=1, LoadInstructions=0, Instruction=0, busy=0, done=0, word_count=0. The buffer contents are don't-care.
- FILL state:
  - CpuReset=1, host_ready=1.
  - A handshake (host_valid & host_ready) writes host_data to buffer[word_count] and increments word_count.
  - If the handshake carries host_last=1, or brings word_count to DEPTH, host_ready drops next cycle and the state goes to STREAM. A full buffer is an implicit last.
  - host_last without host_valid is ignored.
- STREAM state:
  - On entry: CpuReset=0, LoadInstructions=1, Instruction=buffer[0].
  - On the k-th STREAM cycle (k=0..word_count-1), Instruction=buffer[k]. Words are contiguous with no gaps, because the CPU load counter advances every clock.
  - After word_count cycles, LoadInstructions=0 and Instruction=0 on the next cycle, and the state goes to RST2.
  - busy=1 throughout.
- RST2 state:
  - CpuReset=1 for exactly RST_CYCLES cycles (resets PC and pipeline registers); busy=1.
  - Then go to RUN.
- RUN state:
  - CpuReset=0, done=1, host_ready=0.
  - restart=1 for one cycle → next cycle: FILL, word_count=0, CpuReset=1, done=0, host_ready=1.
  - restart is ignored in all other states.
- word_count holds its value through STREAM, RST2 and RUN. It clears only on Reset or restart.
- Simultaneous events:
  - In FILL, a handshake and the buffer-full condition in the same cycle: the word is stored, then the state transitions.
  - restart together with Reset: Reset wins.
- host_data is not sampled when host_ready=0.

Test Plan:
1. Reset low 3 cycles, release → CpuReset=1, host_ready=1, word_count=0, LoadInstructions=0, done=0.
2. Send 4 words 0x20010005, 0x20020003, 0x00221820, 0xAC030000, host_last on the 4th → word_count=4; next cycle LoadInstructions=1 for exactly 4 consecutive cycles carrying those words in order; CpuReset=0 during streaming, then 1 for 2 cycles; then done=1, CpuReset=0.
3. Host inserts 2-cycle valid gaps between 3 words → stream is still 3 contiguous cycles with no bubble, order preserved.
4. Send 32 words, no host_last → host_ready falls after the 32nd handshake, word_count=32, 32-cycle stream; a 33rd valid word is not accepted.
5. Pull Reset low on the 2nd STREAM cycle → LoadInstructions=0, Instruction=0, CpuReset=1, FILL, word_count=0 immediately. A subsequent 2-word load streams correctly.
6. In RUN, pulse restart and load 1 word 0x00000000 with host_last → one-cycle stream, RST_CYCLES CPU reset pulse, done=1. A restart pulse during STREAM has no effect.

Source files
------------

// File: rtl/program_loader.sv
// Buffers a host-supplied program, streams it into the CPU's instruction-load
// port one word per clock, then pulses the CPU reset and releases it to run.
module program_loader #(
  parameter int DEPTH      = 32,
  parameter int AW         = 5,
  parameter int RST_CYCLES = 2
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          host_valid,
  input  logic [31:0]   host_data,
  input  logic          host_last,
  output logic          host_ready,
  input  logic          restart,
  output logic          CpuReset,
  output logic          LoadInstructions,
  output logic [31:0]   Instruction,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [AW:0]    LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {FILL, STREAM, RST2, RUN} LoaderState;

  LoaderState state;
  logic [31:0]    progBuf [DEPTH];
  logic [AW:0]    rdIdx;
  logic [RCW-1:0] rstCnt;
  logic           handshake;

  assign handshake = host_valid & host_ready;

  // Program storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == FILL && handshake)
      progBuf[word_count[AW-1:0]] <= host_data;
  end

  // Sequencer: every output is registered so the CPU sees clean edges.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state            <= FILL;
      host_ready       <= 1'b1;
      CpuReset         <= 1'b1;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      word_count       <= '0;
      rdIdx            <= '0;
      rstCnt           <= '0;
    end else begin
      case (state)
        FILL: begin
          if (handshake) begin
            word_count <= word_count + 1'b1;
            if (host_last || word_count == LAST_IDX) begin
              state            <= STREAM;
              host_ready       <= 1'b0;
              CpuReset         <= 1'b0;
              LoadInstructions <= 1'b1;
              busy             <= 1'b1;
              // A one-word program has not reached the buffer yet.
              Instruction      <= (word_count == '0) ? host_data : progBuf[0];
              rdIdx            <= (AW+1)'(1);
            end
          end
        end

        STREAM: begin
          if (rdIdx == word_count) begin
            state            <= RST2;
            LoadInstructions <= 1'b0;
            Instruction      <= '0;
            CpuReset         <= 1'b1;
            rstCnt           <= '0;
          end else begin
            Instruction <= progBuf[rdIdx[AW-1:0]];
            rdIdx       <= rdIdx + 1'b1;
          end
        end

        RST2: begin
          if (rstCnt == RST_LAST) begin
            state    <= RUN;
            CpuReset <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            rstCnt <= rstCnt + 1'b1;
          end
        end

        RUN: begin
          if (restart) begin
            state      <= FILL;
            word_count <= '0;
            CpuReset   <= 1'b1;
            done       <= 1'b0;
            host_ready <= 1'b1;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a cycle table for the basic load/stream/run
// flow plus hand-written sequences for gaps, full buffer, mid-stream reset, restart.
module tb_program_loader;

  logic        clk;
  logic        Reset;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_last;
  logic        host_ready;
  logic        restart;
  logic        CpuReset;
  logic        LoadInstructions;
  logic [31:0] Instruction;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        rst;
    logic        expReady;
    logic        expCpuReset;
    logic        expLoad;
    logic [31:0] expInstr;
    logic        expBusy;
    logic        expDone;
    logic [5:0]  expCount;
  } Vec;

  Vec vecs[13];

  program_loader #(.DEPTH(32), .AW(5), .RST_CYCLES(2)) dut (
    .clk(clk), .Reset(Reset),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
    .host_ready(host_ready), .restart(restart),
    .CpuReset(CpuReset), .LoadInstructions(LoadInstructions),
    .Instruction(Instruction), .busy(busy), .done(done),
    .word_count(word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Drive inputs for one cycle, then look at the outputs just after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic l, input logic r);
    host_valid = v;
    host_data  = d;
    host_last  = l;
    restart    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic rdy, input logic cr,
                          input logic ld, input logic [31:0] ins, input logic bsy,
                          input logic dn, input logic [5:0] cnt);
    checkOutput({tag, ".host_ready"}, 32'(host_ready), 32'(rdy));
    checkOutput({tag, ".CpuReset"}, 32'(CpuReset), 32'(cr));
    checkOutput({tag, ".LoadInstructions"}, 32'(LoadInstructions), 32'(ld));
    checkOutput({tag, ".Instruction"}, Instruction, ins);
    checkOutput({tag, ".busy"}, 32'(busy), 32'(bsy));
    checkOutput({tag, ".done"}, 32'(done), 32'(dn));
    checkOutput({tag, ".word_count"}, 32'(word_count), 32'(cnt));
  endtask

  task automatic sendWord(input logic [31:0] d, input logic l);
    applyStimulus(1'b1, d, l, 1'b0);
    expQ.push_back(d);
  endtask

  // Expects the queued words as a gapless stream, then the reset pulse and RUN.
  // With poke set, a stray host word and a restart are offered during streaming.
  task automatic streamCheck(input string tag, input bit poke);
    int n;
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s.ld%0d", tag, i), 32'(LoadInstructions), 32'd1);
      checkOutput($sformatf("%s.ins%0d", tag, i), Instruction, expQ[i]);
      checkOutput($sformatf("%s.cr%0d", tag, i), 32'(CpuReset), 32'd0);
      applyStimulus(poke, 32'hDEADBEEF, poke, poke);
    end
    checkAll({tag, ".rst0"}, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 6'(n));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkAll({tag, ".rst1"}, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 6'(n));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkAll({tag, ".run"}, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 6'(n));
  endtask

  task automatic restartToFill(input string tag);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkAll(tag, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    expQ = {};
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 32'h20010005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd1};
    vecs[2]  = '{1'b1, 32'h20020003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd2};
    vecs[3]  = '{1'b1, 32'h00221820, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd3};
    vecs[4]  = '{1'b1, 32'hAC030000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20010005, 1'b1, 1'b0, 6'd4};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20020003, 1'b1, 1'b0, 6'd4};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00221820, 1'b1, 1'b0, 6'd4};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAC030000, 1'b1, 1'b0, 6'd4};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 6'd4};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 6'd4};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 6'd4};
    vecs[11] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 6'd4};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 6'd0};

    Reset      = 1'b1;
    host_valid = 1'b0;
    host_data  = 32'h0;
    host_last  = 1'b0;
    restart    = 1'b0;

    #1 Reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAll("inReset", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    Reset = 1'b1;

    $display("[TB] basic load table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].rst);
      checkAll($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expCpuReset,
               vecs[i].expLoad, vecs[i].expInstr, vecs[i].expBusy,
               vecs[i].expDone, vecs[i].expCount);
    end

    $display("[TB] gapped host words");
    expQ = {};
    sendWord(32'h11110001, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'hBAD0BAD0, 1'b1, 1'b0);
    sendWord(32'h22220002, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'hBAD0BAD0, 1'b1, 1'b0);
    checkOutput("gap.count2", 32'(word_count), 32'd2);
    sendWord(32'h33330003, 1'b1);
    checkOutput("gap.count3", 32'(word_count), 32'd3);
    streamCheck("gap", 1'b0);

    $display("[TB] full buffer");
    restartToFill("full.restart");
    for (int i = 0; i < 32; i++) begin
      if (i == 31)
        checkOutput("full.readyBeforeLast", 32'(host_ready), 32'd1);
      sendWord(32'hA5000000 + 32'(i * 3), 1'b0);
    end
    checkOutput("full.readyDrop", 32'(host_ready), 32'd0);
    checkOutput("full.count", 32'(word_count), 32'd32);
    streamCheck("full", 1'b1);

    $display("[TB] reset during stream");
    restartToFill("midrst.restart");
    sendWord(32'h0000AAA1, 1'b0);
    sendWord(32'h0000AAA2, 1'b0);
    sendWord(32'h0000AAA3, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("midrst.secondWord", Instruction, 32'h0000AAA2);
    #1 Reset = 1'b0;
    #1;
    checkAll("midrst.async", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 6'd0);
    Reset = 1'b1;
    expQ = {};
    sendWord(32'hCAFE0001, 1'b0);
    sendWord(32'hCAFE0002, 1'b1);
    checkOutput("midrst.count", 32'(word_count), 32'd2);
    streamCheck("midrst", 1'b0);

    $display("[TB] restart and single word");
    restartToFill("single.restart");
    sendWord(32'h00000000, 1'b1);
    checkAll("single.entry", 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 6'd1);
    streamCheck("single", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
